cu_sequencer: RTL and testbench

Top-level control sequencer of the multi-cycle LEGv8 core. It owns the fetch/execute state machine, the instruction register (IR) and the NZCV status register. It fetches each instruction over the memory handshake and decodes the instruction class. During execute it forwards the control word and next-state request of the matching class unit (branch, DP-immediate, DP-register, load/store). It sits directly upstream of the class control units: it supplies their `state`, `status` and `IR` inputs and consumes their `NS` and `controlWord` outputs.

---
 rtl/cu_pkg.sv | 53 +++++
 rtl/cu_sequencer_if.sv | 38 +++
 rtl/cu_class_decode.sv | 20 ++
 rtl/cu_sequencer.sv | 95 +++++++++
 tb/tb_cu_sequencer.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/cu_pkg.sv
// Shared definitions for the LEGv8 control sequencer and class units.
// Holds state and class encodings, control-word field positions and the fetch word.
package cu_pkg;

  localparam int unsigned CulDefault = 36;

  typedef enum logic [3:0] {
    StFetch = 4'b0000,
    StEx0   = 4'b0001,
    StEx1   = 4'b0010,
    StEx2   = 4'b0011,
    StHalt  = 4'b1111
  } state_e;

  typedef enum logic [2:0] {
    ClsBr,
    ClsDpi,
    ClsDpr,
    ClsLs,
    ClsIll
  } cls_e;

  // Control-word field positions, LSB first
  localparam int unsigned PcFsLsb       = 0;
  localparam int unsigned PcSelBit      = 2;
  localparam int unsigned DataTriLsb    = 3;
  localparam int unsigned AddTriSelBit  = 5;
  localparam int unsigned SizeLsb       = 6;
  localparam int unsigned StatusLoadBit = 8;
  localparam int unsigned IrLoadBit     = 9;
  localparam int unsigned MemWrEnBit    = 10;
  localparam int unsigned BSelBit       = 11;
  localparam int unsigned MemCsLsb      = 12;
  localparam int unsigned C0Bit         = 14;
  localparam int unsigned WRegBit       = 15;
  localparam int unsigned DaLsb         = 16;
  localparam int unsigned SbLsb         = 21;
  localparam int unsigned SaLsb         = 26;
  localparam int unsigned FsLsb         = 31;
  localparam int unsigned FsMsb         = 35;

  // Fetch word: read memory onto the instruction bus and load IR; PC advances only on ready
  function automatic logic [FsMsb:0] fetch_cw(input logic pc_step);
    logic [FsMsb:0] cw;
    cw                   = '0;
    cw[MemCsLsb+:2]      = 2'b01;
    cw[IrLoadBit]        = 1'b1;
    cw[AddTriSelBit]     = 1'b1;
    cw[PcFsLsb+:2]       = {1'b0, pc_step};
    return cw;
  endfunction

endpackage

// File: rtl/cu_sequencer_if.sv
// Memory, ALU and class-unit signals around the control sequencer.
interface cu_sequencer_if
  import cu_pkg::*;
#(
  parameter int unsigned CUL = CulDefault
);
  logic            mem_ready;
  logic [31:0]     mem_data;
  logic [3:0]      alu_status;
  logic [CUL:0]    cw_br;
  logic [CUL:0]    cw_dpi;
  logic [CUL:0]    cw_dpr;
  logic [CUL:0]    cw_ls;
  logic [3:0]      ns_br;
  logic [3:0]      ns_dpi;
  logic [3:0]      ns_dpr;
  logic [3:0]      ns_ls;
  logic [31:0]     IR;
  logic [3:0]      state;
  logic [3:0]      status;
  logic [CUL:0]    controlWord;
  logic            illegal;

  modport master (
    input  mem_ready, mem_data, alu_status,
    input  cw_br, cw_dpi, cw_dpr, cw_ls,
    input  ns_br, ns_dpi, ns_dpr, ns_ls,
    output IR, state, status, controlWord, illegal
  );

  modport slave (
    output mem_ready, mem_data, alu_status,
    output cw_br, cw_dpi, cw_dpr, cw_ls,
    output ns_br, ns_dpi, ns_dpr, ns_ls,
    input  IR, state, status, controlWord, illegal
  );

endinterface

// File: rtl/cu_class_decode.sv
// Maps the instruction-class field IR[28:25] to the class enum.
module cu_class_decode
  import cu_pkg::*;
(
  input  logic [3:0] op_i,
  output cls_e       cls_o
);

  always_comb begin
    cls_o = ClsIll;
    unique casez (op_i)
      4'b100?: cls_o = ClsDpi;
      4'b101?: cls_o = ClsBr;
      4'b?1?0: cls_o = ClsLs;
      4'b?101: cls_o = ClsDpr;
      default: cls_o = ClsIll;
    endcase
  end

endmodule

// File: rtl/cu_sequencer.sv
// Fetch/execute sequencer: owns IR, NZCV and the state register, and forwards the
// control word and next-state request of the class unit selected by IR.
module cu_sequencer
  import cu_pkg::*;
#(
  parameter int unsigned CUL = CulDefault
) (
  input logic            clock,
  input logic            reset_n,
  cu_sequencer_if.master bus
);

  state_e       state_q;
  logic [31:0]  ir_q;
  logic [3:0]   status_q;
  logic         illegal_q;

  cls_e         cls;
  logic [CUL:0] cw_sel;
  logic [3:0]   ns_sel;
  logic [CUL:0] cw;
  state_e       ex_next;

  cu_class_decode u_decode (
    .op_i  (ir_q[28:25]),
    .cls_o (cls)
  );

  // An illegal class requests an out-of-range state so it lands in HALT like a bad ns
  always_comb begin
    cw_sel = '0;
    ns_sel = 4'hF;
    unique case (cls)
      ClsBr:   begin cw_sel = bus.cw_br;  ns_sel = bus.ns_br;  end
      ClsDpi:  begin cw_sel = bus.cw_dpi; ns_sel = bus.ns_dpi; end
      ClsDpr:  begin cw_sel = bus.cw_dpr; ns_sel = bus.ns_dpr; end
      ClsLs:   begin cw_sel = bus.cw_ls;  ns_sel = bus.ns_ls;  end
      default: begin cw_sel = '0;         ns_sel = 4'hF;       end
    endcase
  end

  always_comb begin
    case (ns_sel)
      4'h0:    ex_next = StFetch;
      4'h1:    ex_next = StEx0;
      4'h2:    ex_next = StEx1;
      4'h3:    ex_next = StEx2;
      default: ex_next = StHalt;
    endcase
  end

  // PC stepping is gated by reset so the fetch word holds PC while reset is asserted
  always_comb begin
    cw = '0;
    case (state_q)
      StFetch: cw[FsMsb:0] = fetch_cw(bus.mem_ready & reset_n);
      StEx0, StEx1, StEx2: begin
        cw               = cw_sel;
        cw[CUL:FsMsb+1]  = '0;
      end
      default: cw = '0;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StFetch;
      ir_q      <= '0;
      status_q  <= '0;
      illegal_q <= 1'b0;
    end else begin
      case (state_q)
        StFetch: begin
          if (bus.mem_ready) begin
            ir_q    <= bus.mem_data;
            state_q <= StEx0;
          end
        end
        StEx0, StEx1, StEx2: begin
          state_q <= ex_next;
          if (cw[StatusLoadBit]) status_q <= bus.alu_status;
          if (ex_next == StHalt) illegal_q <= 1'b1;
        end
        default: state_q <= StHalt;
      endcase
    end
  end

  assign bus.IR          = ir_q;
  assign bus.state       = state_q;
  assign bus.status      = status_q;
  assign bus.controlWord = cw;
  assign bus.illegal     = illegal_q;

endmodule

// File: tb/tb_cu_sequencer.sv
// Directed and randomized checks of cu_sequencer against a cycle-level reference model.
module tb_cu_sequencer;

  localparam int unsigned CUL = 36;
  localparam logic [36:0] FetchBase = 37'h0_0000_1220;
  localparam logic [36:0] CwMask    = 37'h0F_FFFF_FFFF;

  logic clock;
  logic reset_n;
  int   checks;
  int   failures;

  // Reference model: state as a number, plus the architectural registers
  int          m_state;
  logic [31:0] m_ir;
  logic [3:0]  m_status;
  logic        m_illegal;

  cu_sequencer_if #(.CUL(CUL)) bus ();

  cu_sequencer #(.CUL(CUL)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // 0 br, 1 dpi, 2 dpr, 3 ls, 4 illegal
  function automatic int cls_of(input logic [31:0] ir);
    int op;
    op = int'(ir[28:25]);
    if ((op >> 1) == 4) return 1;
    if ((op >> 1) == 5) return 0;
    if ((op & 5) == 4) return 3;
    if ((op & 7) == 5) return 2;
    return 4;
  endfunction

  function automatic logic [36:0] sel_cw(input int c);
    case (c)
      0: return bus.cw_br;
      1: return bus.cw_dpi;
      2: return bus.cw_dpr;
      3: return bus.cw_ls;
      default: return '0;
    endcase
  endfunction

  function automatic logic [3:0] sel_ns(input int c);
    case (c)
      0: return bus.ns_br;
      1: return bus.ns_dpi;
      2: return bus.ns_dpr;
      3: return bus.ns_ls;
      default: return 4'hF;
    endcase
  endfunction

  function automatic logic [36:0] rnd_cw();
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    return t[36:0];
  endfunction

  function automatic logic [3:0] rnd_ns();
    if ($urandom_range(0, 15) < 14) return 4'($urandom_range(0, 3));
    return 4'($urandom_range(4, 15));
  endfunction

  function automatic logic [36:0] exp_cw();
    int c;
    c = cls_of(m_ir);
    if (m_state == 0) return FetchBase | 37'(bus.mem_ready);
    if (m_state == 15 || c == 4) return '0;
    return sel_cw(c) & CwMask;
  endfunction

  task automatic rnd_inputs();
    bus.mem_ready  = 1'($urandom_range(0, 1));
    bus.mem_data   = $urandom();
    bus.alu_status = 4'($urandom_range(0, 15));
    bus.cw_br      = rnd_cw();
    bus.cw_dpi     = rnd_cw();
    bus.cw_dpr     = rnd_cw();
    bus.cw_ls      = rnd_cw();
    bus.ns_br      = rnd_ns();
    bus.ns_dpi     = rnd_ns();
    bus.ns_dpr     = rnd_ns();
    bus.ns_ls      = rnd_ns();
  endtask

  // Called at a falling edge with inputs already applied; returns at the next falling edge
  task automatic step();
    logic [36:0] ecw;
    logic [3:0]  ns;
    logic        mr;
    logic [31:0] data;
    logic [3:0]  alu;
    int          c;
    #1;
    ecw = exp_cw();
    c   = cls_of(m_ir);
    ns  = (c == 4) ? 4'hF : sel_ns(c);
    mr = bus.mem_ready; data = bus.mem_data; alu = bus.alu_status;
    chk("state", 64'(bus.state), 64'(m_state));
    chk("ir", 64'(bus.IR), 64'(m_ir));
    chk("status", 64'(bus.status), 64'(m_status));
    chk("illegal", 64'(bus.illegal), 64'(m_illegal));
    chk("cw", 64'(bus.controlWord), 64'(ecw));
    @(posedge clock);
    if (m_state == 0) begin
      if (mr) begin
        m_ir    = data;
        m_state = 1;
      end
    end else if (m_state >= 1 && m_state <= 3) begin
      if (ecw[8]) m_status = alu;
      if (ns == 4'h0) m_state = 0;
      else if (ns <= 4'h3) m_state = int'(ns);
      else begin
        m_state   = 15;
        m_illegal = 1'b1;
      end
    end
    @(negedge clock);
  endtask

  // Asynchronous reset pulse in the middle of a cycle, with fetch-ready high
  task automatic do_reset();
    bus.mem_ready = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    m_state = 0; m_ir = '0; m_status = '0; m_illegal = 1'b0;
    chk("rst_state", 64'(bus.state), 64'd0);
    chk("rst_ir", 64'(bus.IR), 64'd0);
    chk("rst_status", 64'(bus.status), 64'd0);
    chk("rst_illegal", 64'(bus.illegal), 64'd0);
    chk("rst_cw", 64'(bus.controlWord), 64'(FetchBase));
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  initial begin
    checks = 0; failures = 0;
    reset_n = 1'b0;
    rnd_inputs();
    bus.mem_ready = 1'b1;
    m_state = 0; m_ir = '0; m_status = '0; m_illegal = 1'b0;
    #1;
    chk("init_state", 64'(bus.state), 64'd0);
    chk("init_cw", 64'(bus.controlWord), 64'(FetchBase));
    @(negedge clock);
    reset_n = 1'b1;

    // Slow fetch of a B instruction, then single-cycle branch back to FETCH
    bus.mem_ready = 1'b0;
    step();
    chk("slow_pcfs0", 64'(bus.controlWord[1:0]), 64'd0);
    step();
    bus.mem_ready = 1'b1; bus.mem_data = 32'h1400_0004; bus.ns_br = 4'h0;
    #1 chk("slow_pcfs1", 64'(bus.controlWord[1:0]), 64'd1);
    step();
    chk("b_ir", 64'(bus.IR), 64'h1400_0004);
    chk("b_state", 64'(bus.state), 64'd1);
    chk("b_cw", 64'(bus.controlWord), 64'(bus.cw_br & CwMask));
    step();
    chk("b_back", 64'(bus.state), 64'd0);

    // Two-cycle CBZ with a status write in EX0
    bus.mem_data = 32'hB400_0040;
    step();
    bus.cw_br[8] = 1'b1; bus.ns_br = 4'h2; bus.alu_status = 4'b0100;
    step();
    chk("cbz_status", 64'(bus.status), 64'h4);
    chk("cbz_state", 64'(bus.state), 64'd2);
    bus.cw_br[8] = 1'b0; bus.ns_br = 4'h0; bus.alu_status = 4'b1011;
    step();
    chk("cbz_back", 64'(bus.state), 64'd0);
    chk("cbz_hold", 64'(bus.status), 64'h4);

    // DP-register class, visiting EX2
    bus.mem_data = 32'h8B02_0020;
    step();
    bus.ns_dpr = 4'h3;
    #1 chk("dpr_cw", 64'(bus.controlWord), 64'(bus.cw_dpr & CwMask));
    step();
    chk("dpr_ex2", 64'(bus.state), 64'd3);
    bus.ns_dpr = 4'h0;
    step();

    // Reset in EX1
    bus.mem_data = 32'h1400_0004; bus.ns_br = 4'h2;
    step();
    step();
    chk("ex1_reached", 64'(bus.state), 64'd2);
    do_reset();

    // Illegal instruction word, held in HALT for 10 cycles under random inputs
    bus.mem_ready = 1'b1; bus.mem_data = 32'h0;
    step();
    #1 chk("ill_cw", 64'(bus.controlWord), 64'd0);
    step();
    for (int i = 0; i < 10; i++) begin
      rnd_inputs();
      step();
    end
    chk("halt_state", 64'(bus.state), 64'hF);
    chk("halt_ill", 64'(bus.illegal), 64'd1);
    do_reset();

    // Load/store requesting an out-of-range state
    bus.mem_ready = 1'b1; bus.mem_data = 32'hF840_0000; bus.ns_ls = 4'h6;
    step();
    step();
    chk("ls_halt", 64'(bus.state), 64'hF);
    do_reset();

    // Randomized run; escape HALT with a reset after a few cycles
    for (int n = 0; n < 1500; n++) begin
      rnd_inputs();
      if ((m_state == 15 && $urandom_range(0, 3) == 0) || $urandom_range(0, 199) == 0)
        do_reset();
      else
        step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
